// File: rtl/seg7_pkg.sv
// seg7_pkg: constants shared by the 7-segment scan driver and its hex decoder.
// Segment byte order is {a,b,c,d,e,f,g,dp}, all active-low (0 = segment lit).
// The hex table holds a..g only; the caller appends the decimal point.
package seg7_pkg;

  // Bit positions inside the 8-bit segment byte
  localparam int SEG_A_BIT  = 7;
  localparam int SEG_G_BIT  = 1;
  localparam int SEG_DP_BIT = 0;

  // All segments dark
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // a..g glyphs, active-low; entry n is the glyph for nibble value n
  localparam logic [15:0][6:0] HEX_SEG = {
    7'b0111000,  // F
    7'b0110000,  // E
    7'b1000010,  // d
    7'b0110001,  // C
    7'b1100000,  // b
    7'b0001000,  // A
    7'b0000100,  // 9
    7'b0000000,  // 8
    7'b0001111,  // 7
    7'b0100000,  // 6
    7'b0100100,  // 5
    7'b1001100,  // 4
    7'b0000110,  // 3
    7'b0010010,  // 2
    7'b1001111,  // 1
    7'b0000001   // 0
  };

endpackage

// File: rtl/seg7_hex_decode.sv
// seg7_hex_decode: 4-bit nibble to active-low a..g glyph.
// Latency: combinational, zero cycles.
// Backpressure: none; pure lookup.
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [6:0] seg_o
);

  assign seg_o = HEX_SEG[nib_i];

endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: multiplexed 7-segment driver, graph/hex modes, 16-step PWM dimming,
// double-buffered display data swapped at frame boundaries. Blinking only with SEG7_BLINK_EN.
// Latency: seg_out/anode_out registered, one cycle after the scan state; no backpressure.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int SCAN_DIV     = 50000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [8*NUM_DIGITS-1:0] disp_num,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank_mask,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  input  logic                    load,
  input  logic                    mode,
  input  logic                    page,
  input  logic [3:0]              brightness,
  output logic [7:0]              seg_out,
  output logic [NUM_DIGITS-1:0]   anode_out,
  output logic                    frame_done
);

  // A slot is 16 PWM phases of PH_LEN cycles; slot cycle = phase*PH_LEN + sub.
  localparam int PH_LEN = SCAN_DIV / 16;
  localparam int SUB_W  = (PH_LEN > 1) ? $clog2(PH_LEN) : 1;
  localparam int IDX_W  = $clog2(NUM_DIGITS);
  localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(PH_LEN - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  logic [SUB_W-1:0] sub_q, sub_d;
  logic [3:0]       phase_q, phase_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             slot_end, frame_end;

  logic [8*NUM_DIGITS-1:0] stg_num_q, sh_num_q;
  logic [NUM_DIGITS-1:0]   stg_dp_q, sh_dp_q, stg_blank_q, sh_blank_q;
  logic                    pend_q, pend_d, xfer;

  logic [7:0]            seg_q, seg_d;
  logic [NUM_DIGITS-1:0] anode_q, anode_d;
  logic                  fd_q;

  logic [4*NUM_DIGITS-1:0] hex_page;
  logic [3:0]              nib;
  logic [6:0]              hex_seg;
  logic                    blink_dark, lit;

  assign slot_end  = (sub_q == SUB_LAST) && (phase_q == 4'hF);
  assign frame_end = slot_end && (idx_q == IDX_LAST);

  // Next scan position: sub-counter within a phase, phase within a slot, digit per slot
  always_comb begin
    sub_d   = sub_q + SUB_W'(1);
    phase_d = phase_q;
    idx_d   = idx_q;
    if (sub_q == SUB_LAST) begin
      sub_d   = '0;
      phase_d = phase_q + 4'd1;
      if (slot_end) idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
    end
  end

  // Scan position registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sub_q   <= '0;
      phase_q <= '0;
      idx_q   <= '0;
    end else begin
      sub_q   <= sub_d;
      phase_q <= phase_d;
      idx_q   <= idx_d;
    end
  end

  // Pending is set by a load and consumed at the frame boundary; a load landing
  // exactly on the boundary goes straight to the shadow, so nothing stays pending.
  always_comb begin
    pend_d = pend_q;
    if (load)      pend_d = 1'b1;
    if (frame_end) pend_d = 1'b0;
  end

  assign xfer = frame_end && (pend_q || load);

  // Staging captures every load; shadow only changes between frames so a scan never tears
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stg_num_q   <= '0;
      stg_dp_q    <= '0;
      stg_blank_q <= '0;
      sh_num_q    <= '0;
      sh_dp_q     <= '0;
      sh_blank_q  <= '0;
      pend_q      <= 1'b0;
    end else begin
      pend_q <= pend_d;
      if (load) begin
        stg_num_q   <= disp_num;
        stg_dp_q    <= dp_in;
        stg_blank_q <= blank_mask;
      end
      if (xfer) begin
        sh_num_q   <= load ? disp_num   : stg_num_q;
        sh_dp_q    <= load ? dp_in      : stg_dp_q;
        sh_blank_q <= load ? blank_mask : stg_blank_q;
      end
    end
  end

`ifdef SEG7_BLINK_EN
  localparam int BC_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [BC_W-1:0] BC_LAST = BC_W'(BLINK_FRAMES - 1);

  logic [NUM_DIGITS-1:0] stg_blink_q, sh_blink_q;
  logic [BC_W-1:0]       bcnt_q, bcnt_d;
  logic                  bphase_q, bphase_d;

  // Frame counter toggles the blink phase every BLINK_FRAMES frames
  always_comb begin
    bcnt_d   = bcnt_q;
    bphase_d = bphase_q;
    if (frame_end) begin
      if (bcnt_q == BC_LAST) begin
        bcnt_d   = '0;
        bphase_d = ~bphase_q;
      end else begin
        bcnt_d = bcnt_q + BC_W'(1);
      end
    end
  end

  // Blink mask follows the same staging/shadow path as the display data
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stg_blink_q <= '0;
      sh_blink_q  <= '0;
      bcnt_q      <= '0;
      bphase_q    <= 1'b0;
    end else begin
      bcnt_q   <= bcnt_d;
      bphase_q <= bphase_d;
      if (load) stg_blink_q <= blink_mask;
      if (xfer) sh_blink_q  <= load ? blink_mask : stg_blink_q;
    end
  end

  assign blink_dark = bphase_q && sh_blink_q[idx_q];
`else
  logic unused_blink;
  assign unused_blink = ^blink_mask;
  assign blink_dark   = 1'b0;
`endif

  // Hex nibble for the current digit from the selected page
  assign hex_page = page ? sh_num_q[8*NUM_DIGITS-1:4*NUM_DIGITS] : sh_num_q[4*NUM_DIGITS-1:0];
  assign nib      = hex_page[{idx_q, 2'b00} +: 4];

  seg7_hex_decode u_hex (
    .nib_i (nib),
    .seg_o (hex_seg)
  );

  assign lit = (phase_q <= brightness) && !sh_blank_q[idx_q] && !blink_dark;

  // Segment/anode pattern for the current scan state; segments go dark with the anode
  always_comb begin
    seg_d   = SEG_BLANK;
    anode_d = '1;
    if (lit) begin
      anode_d = ~({{(NUM_DIGITS-1){1'b0}}, 1'b1} << idx_q);
      if (mode) begin
        seg_d[SEG_A_BIT:SEG_G_BIT] = hex_seg;
        seg_d[SEG_DP_BIT]          = ~sh_dp_q[idx_q];
      end else begin
        seg_d = sh_num_q[{idx_q, 3'b000} +: 8];
      end
    end
  end

  // Output registers; frame_done lands in the cycle after the boundary
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_q   <= SEG_BLANK;
      anode_q <= '1;
      fd_q    <= 1'b0;
    end else begin
      seg_q   <= seg_d;
      anode_q <= anode_d;
      fd_q    <= frame_end;
    end
  end

  assign seg_out    = seg_q;
  assign anode_out  = anode_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: directed stimulus with a scoreboard of expectations keyed by the
// cycle count since reset release; a negedge monitor pops and compares them.
// NUM_DIGITS=4, SCAN_DIV=16 (one cycle per PWM phase), BLINK_FRAMES=2; 64 cycles per frame.
module tb_seg7_scan_driver;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] disp_num;
  logic [3:0]  dp_in, blank_mask, blink_mask;
  logic        load, mode, page;
  logic [3:0]  brightness;
  logic [7:0]  seg_out;
  logic [3:0]  anode_out;
  logic        frame_done;

  seg7_scan_driver #(
    .NUM_DIGITS   (4),
    .SCAN_DIV     (16),
    .BLINK_FRAMES (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .disp_num   (disp_num),
    .dp_in      (dp_in),
    .blank_mask (blank_mask),
    .blink_mask (blink_mask),
    .load       (load),
    .mode       (mode),
    .page       (page),
    .brightness (brightness),
    .seg_out    (seg_out),
    .anode_out  (anode_out),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  // Posedges since reset release: after posedge t the outputs show scan position t-1
  int tcount = 0;
  always @(posedge clk or posedge rst) begin
    if (rst) tcount <= 0;
    else     tcount <= tcount + 1;
  end

  typedef struct {
    int          t;
    logic [7:0]  seg;
    logic [3:0]  an;
    logic        fd;
    string       nm;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_tmo    = 0;

  task automatic push(input int t, input logic [7:0] s, input logic [3:0] a,
                      input logic f, input string nm);
    exp_t e;
    e.t = t; e.seg = s; e.an = a; e.fd = f; e.nm = nm;
    sb.push_back(e);
  endtask

  task automatic wait_t(input int n);
    while (tcount < n) @(negedge clk);
  endtask

  task automatic drain(input int budget);
    int k;
    k = 0;
    while (sb.size() > 0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (sb.size() > 0) begin
      n_tmo++;
      $display("FAIL drain: %0d expectations still queued, required 0", sb.size());
      sb.delete();
    end
  endtask

  // Monitor: compare every expectation whose cycle has come
  always @(negedge clk) begin : mon
    exp_t e;
    while (sb.size() > 0) begin
      if (sb[0].t > tcount) break;
      e = sb.pop_front();
      n_checks++;
      if (e.t < tcount)
        $display("FAIL %s: sample slot t=%0d missed (now t=%0d)", e.nm, e.t, tcount);
      else if (seg_out !== e.seg || anode_out !== e.an || frame_done !== e.fd)
        $display("FAIL %s t=%0d: got seg=%h an=%b fd=%b, required seg=%h an=%b fd=%b",
                 e.nm, e.t, seg_out, anode_out, frame_done, e.seg, e.an, e.fd);
      else
        n_pass++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; load = 1'b0; disp_num = '0; dp_in = '0; blank_mask = '0; blink_mask = '0;
    mode = 1'b1; page = 1'b0; brightness = 4'd15;
    #1 rst = 1'b1;

    // Session 1 expectations (t = posedges since release)
    push(0,   8'hFF, 4'b1111, 1'b0, "reset_state");
    push(2,   8'h03, 4'b1110, 1'b0, "preframe_old_shadow");
    push(63,  8'h03, 4'b0111, 1'b0, "frame_done_low_before");
    push(64,  8'h03, 4'b0111, 1'b1, "frame_done_pulse");
    push(65,  8'h99, 4'b1110, 1'b0, "hex_p0_d0_4");
    push(81,  8'h0D, 4'b1101, 1'b0, "hex_p0_d1_3");
    push(97,  8'h25, 4'b1011, 1'b0, "hex_p0_d2_2");
    push(113, 8'h9F, 4'b0111, 1'b0, "hex_p0_d3_1");
    push(132, 8'h03, 4'b1110, 1'b0, "page1_live_old_shadow");
    push(193, 8'h85, 4'b1110, 1'b0, "page1_d0_D");
    push(209, 8'h63, 4'b1101, 1'b0, "page1_d1_C");
    push(241, 8'h11, 4'b0111, 1'b0, "page1_d3_A");
    for (int i = 0; i < 16; i++)
      push(257 + i, (i < 4) ? 8'h85 : 8'hFF, (i < 4) ? 4'b1110 : 4'b1111, 1'b0, "pwm_b3");
    push(342, 8'h63, 4'b1101, 1'b0, "midload_d1_unchanged");
    push(353, 8'hC1, 4'b1011, 1'b0, "midload_d2_unchanged");
    push(369, 8'h11, 4'b0111, 1'b0, "midload_d3_unchanged");
    push(384, 8'h11, 4'b0111, 1'b1, "midload_frame_done");
    push(385, 8'h01, 4'b1110, 1'b0, "midload_d0_new_8");
    push(401, 8'h1F, 4'b1101, 1'b0, "midload_d1_new_7");
    push(452, 8'h00, 4'b1110, 1'b0, "graph_live_old_byte");
    push(513, 8'h44, 4'b1110, 1'b0, "graph_d0");
    push(529, 8'h33, 4'b1101, 1'b0, "graph_d1");
    push(542, 8'h98, 4'b1101, 1'b0, "hex_dp_d1");
    push(545, 8'h0D, 4'b1011, 1'b0, "hex_nodp_d2");
    push(561, 8'hFF, 4'b1111, 1'b0, "blank_d3");

    repeat (3) @(negedge clk);
    rst = 1'b0;

    wait_t(1);
    load = 1'b1; disp_num = 32'h0000_1234;
    @(negedge clk) load = 1'b0;

    wait_t(130);
    page = 1'b1; load = 1'b1; disp_num = 32'hABCD_0000;
    @(negedge clk) load = 1'b0;

    wait_t(250); brightness = 4'd3;
    wait_t(280); brightness = 4'd15;

    wait_t(340);
    load = 1'b1; disp_num = 32'h5678_0000;
    @(negedge clk) load = 1'b0;

    wait_t(450);
    mode = 1'b0; load = 1'b1; disp_num = 32'h1122_3344; dp_in = 4'b0010; blank_mask = 4'b1000;
    @(negedge clk) load = 1'b0;

    wait_t(540);
    mode = 1'b1; page = 1'b0;

    // Load at digit1 of frame 9, then reset at digit2 slot cycle 7 before it applies
    wait_t(595);
    load = 1'b1; disp_num = 32'h0000_FFFF; dp_in = 4'b0000; blank_mask = 4'b0000;
    @(negedge clk) load = 1'b0;
    drain(100);
    wait_t(614);
    @(posedge clk);
    #2 rst = 1'b1;

    // Session 2 expectations
    push(0,   8'hFF, 4'b1111, 1'b0, "rst_async_midframe");
    push(1,   8'h03, 4'b1110, 1'b0, "restart_d0");
    push(17,  8'h03, 4'b1101, 1'b0, "restart_d1");
    push(66,  8'h03, 4'b1110, 1'b0, "pending_discarded");
`ifdef SEG7_BLINK_EN
    push(130, 8'hFF, 4'b1111, 1'b0, "blink_f2_dark");
`else
    push(130, 8'h99, 4'b1110, 1'b0, "noblink_f2_lit");
`endif
    push(146, 8'h0D, 4'b1101, 1'b0, "blink_f2_d1_unmasked");
`ifdef SEG7_BLINK_EN
    push(194, 8'hFF, 4'b1111, 1'b0, "blink_f3_dark");
`else
    push(194, 8'h99, 4'b1110, 1'b0, "noblink_f3_lit");
`endif
    push(258, 8'h99, 4'b1110, 1'b0, "blink_f4_lit");
    push(306, 8'h71, 4'b0111, 1'b0, "hex_d3_F");
    push(322, 8'h99, 4'b1110, 1'b0, "blink_f5_lit");
`ifdef SEG7_BLINK_EN
    push(386, 8'hFF, 4'b1111, 1'b0, "blink_f6_dark");
`else
    push(386, 8'h99, 4'b1110, 1'b0, "noblink_f6_lit");
`endif

    repeat (3) @(negedge clk);
    rst = 1'b0;

    wait_t(70);
    load = 1'b1; disp_num = 32'h0000_F234; blink_mask = 4'b0001;
    @(negedge clk) load = 1'b0;

    drain(500);
    $display("%0d/%0d checks passed", n_pass, n_checks + n_tmo);
    $finish;
  end

endmodule
